weight_fetch_sched: RTL and testbench

//  Sequences EPU-side reads of the 180 KB weight SRAM (sp_ram_intf memory port,
//  EPU_RW path). Streams LEN consecutive 32-bit words from BASE, REP times
//  (weight reuse across output tiles), into a valid/ready stream for the PE array.

---
 rtl/weight_fetch_sched.sv | 161 ++++++++++++++++
 tb/tb_weight_fetch_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/weight_fetch_sched.sv
// Weight SRAM read sequencer: streams LEN consecutive words from BASE, REP passes, into a
// valid/ready stream. A 2-slot buffer absorbs the 1-cycle SRAM latency and consumer stalls.
module weight_fetch_sched #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 16,
  parameter int REP_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic [REP_W-1:0]  rep_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              sram_gnt_i,
  output logic              sram_cs_o,
  output logic              sram_oe_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_wreq_o,
  input  logic [DATA_W-1:0] sram_rdata_i,
  output logic              wt_valid_o,
  output logic [DATA_W-1:0] wt_data_o,
  output logic              wt_last_o,
  input  logic              wt_ready_i
);
  localparam logic WRITE_DIS = 1'b0;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [LEN_W-1:0]  len_q, len_d, word_cnt_q, word_cnt_d;
  logic [REP_W-1:0]  rep_q, rep_d, pass_cnt_q, pass_cnt_d;
  logic              infl_q, infl_d, infl_last_q, infl_last_d;
  logic [1:0]        occ_q, occ_d;
  logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] buf_data_q [2];
  logic              buf_last_q [2];

  logic              issue, last_word, last_pass, buf_nonempty;
  logic              valid, pop, pop_buf, push, head_last;
  logic [DATA_W-1:0] head_data;

  assign last_word    = (word_cnt_q == len_q - LEN_W'(1));
  assign last_pass    = (pass_cnt_q == rep_q - REP_W'(1));
  assign buf_nonempty = (occ_q != 2'd0);
  assign issue        = (state_q == S_FETCH) && sram_gnt_i && !abort_i &&
                        (({1'b0, occ_q} + {2'b00, infl_q}) < 3'd2);

  // The word in flight is presented straight off the SRAM bus, behind any buffered entries.
  assign valid     = buf_nonempty || infl_q;
  assign head_data = buf_nonempty ? buf_data_q[rd_ptr_q] : sram_rdata_i;
  assign head_last = buf_nonempty ? buf_last_q[rd_ptr_q] : infl_last_q;
  assign pop       = valid && wt_ready_i;
  assign pop_buf   = pop && buf_nonempty;
  assign push      = infl_q && !(pop && !buf_nonempty);

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    len_d       = len_q;
    rep_d       = rep_q;
    word_cnt_d  = word_cnt_q;
    pass_cnt_d  = pass_cnt_q;
    infl_d      = issue;
    infl_last_d = issue && last_word;
    occ_d       = occ_q + {1'b0, push} - {1'b0, pop_buf};
    wr_ptr_d    = wr_ptr_q ^ push;
    rd_ptr_d    = rd_ptr_q ^ pop_buf;

    if (issue) begin
      if (last_word) begin
        word_cnt_d = '0;
        pass_cnt_d = pass_cnt_q + REP_W'(1);
      end else begin
        word_cnt_d = word_cnt_q + LEN_W'(1);
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          base_d     = base_i;
          len_d      = len_i;
          rep_d      = rep_i;
          word_cnt_d = '0;
          pass_cnt_d = '0;
          state_d    = (len_i == '0 || rep_i == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: if (issue && last_word && last_pass) state_d = S_DRAIN;
      S_DRAIN: if (occ_d == 2'd0 && !infl_d) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (abort_i && state_q != S_IDLE) begin
      state_d     = S_IDLE;
      infl_d      = 1'b0;
      infl_last_d = 1'b0;
      occ_d       = 2'd0;
      wr_ptr_d    = 1'b0;
      rd_ptr_d    = 1'b0;
      word_cnt_d  = '0;
      pass_cnt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      rep_q       <= '0;
      word_cnt_q  <= '0;
      pass_cnt_q  <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      occ_q       <= 2'd0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      rep_q       <= rep_d;
      word_cnt_q  <= word_cnt_d;
      pass_cnt_q  <= pass_cnt_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      occ_q       <= occ_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_data_q[0] <= '0;
      buf_data_q[1] <= '0;
      buf_last_q[0] <= 1'b0;
      buf_last_q[1] <= 1'b0;
    end else if (push) begin
      buf_data_q[wr_ptr_q] <= sram_rdata_i;
      buf_last_q[wr_ptr_q] <= infl_last_q;
    end
  end

  assign busy_o      = (state_q == S_FETCH) || (state_q == S_DRAIN);
  assign done_o      = (state_q == S_DONE);
  assign sram_cs_o   = issue;
  assign sram_oe_o   = issue;
  assign sram_addr_o = issue ? (base_q + ADDR_W'(word_cnt_q)) : '0;
  assign sram_wreq_o = WRITE_DIS;
  assign wt_valid_o  = valid;
  assign wt_data_o   = valid ? head_data : '0;
  assign wt_last_o   = valid && head_last;
endmodule

// File: tb/tb_weight_fetch_sched.sv
// Bench for weight_fetch_sched: directed jobs plus randomized gnt/ready jobs, checked
// against an address/word-order reference and a synchronous SRAM model.
module tb_weight_fetch_sched;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;
  localparam int REP_W  = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start_i, abort_i, sram_gnt_i, wt_ready_i;
  logic [ADDR_W-1:0] base_i;
  logic [LEN_W-1:0]  len_i;
  logic [REP_W-1:0]  rep_i;
  logic [DATA_W-1:0] sram_rdata_i;
  logic              busy_o, done_o, sram_cs_o, sram_oe_o, sram_wreq_o;
  logic              wt_valid_o, wt_last_o;
  logic [ADDR_W-1:0] sram_addr_o;
  logic [DATA_W-1:0] wt_data_o;

  always #5 clk = ~clk;

  weight_fetch_sched #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .REP_W(REP_W)) u_dut (
    .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
    .base_i(base_i), .len_i(len_i), .rep_i(rep_i),
    .busy_o(busy_o), .done_o(done_o),
    .sram_gnt_i(sram_gnt_i), .sram_cs_o(sram_cs_o), .sram_oe_o(sram_oe_o),
    .sram_addr_o(sram_addr_o), .sram_wreq_o(sram_wreq_o), .sram_rdata_i(sram_rdata_i),
    .wt_valid_o(wt_valid_o), .wt_data_o(wt_data_o), .wt_last_o(wt_last_o),
    .wt_ready_i(wt_ready_i)
  );

  int n_chk = 0;
  int n_err = 0;
  int fv;

  logic              pend;
  logic [ADDR_W-1:0] pend_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [ADDR_W-1:0] a);
    return ({15'h0, a} * 32'h9E37_79B1) ^ 32'hA5C3_0000;
  endfunction

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},  busy_o, 0);
    chk({tag, "_done"},  done_o, 0);
    chk({tag, "_cs"},    sram_cs_o, 0);
    chk({tag, "_oe"},    sram_oe_o, 0);
    chk({tag, "_addr"},  sram_addr_o, 0);
    chk({tag, "_valid"}, wt_valid_o, 0);
    chk({tag, "_data"},  wt_data_o, 0);
    chk({tag, "_last"},  wt_last_o, 0);
  endtask

  // One job; k counts cycles from the start_i cycle (k=0). kill_k >= 0 ends the job at
  // that cycle with abort_i (kill_rst=0) or an async reset pulse (kill_rst=1).
  task automatic run_job(input logic [ADDR_W-1:0] base, input int len, input int rep,
                         input int rdy_lo, input int rdy_hi, input int gnt_lo, input int gnt_hi,
                         input bit rnd, input int kill_k, input bit kill_rst, output int first_v);
    logic [ADDR_W-1:0] exp_addr[$];
    int total, iss, dlv, k, last_hs;
    bit prev_hold, exp_iss;
    logic [DATA_W-1:0] prev_data;
    logic prev_last;

    total = len * rep;
    for (int p = 0; p < rep; p++)
      for (int w = 0; w < len; w++) exp_addr.push_back(ADDR_W'(base + w));
    iss = 0; dlv = 0; k = 0; last_hs = -10; first_v = -1;
    prev_hold = 0; prev_data = '0; prev_last = 0; pend = 0;

    forever begin
      start_i      = (k == 0);
      base_i       = base;
      len_i        = LEN_W'(len);
      rep_i        = REP_W'(rep);
      abort_i      = (k == kill_k) && !kill_rst;
      wt_ready_i   = !((k >= rdy_lo && k <= rdy_hi) || (rnd && $urandom_range(2) == 0));
      sram_gnt_i   = !((k >= gnt_lo && k <= gnt_hi) || (rnd && $urandom_range(3) == 0));
      sram_rdata_i = pend ? memf(pend_addr) : $urandom;
      @(negedge clk);

      exp_iss = (k >= 1) && (iss < total) && sram_gnt_i && ((iss - dlv) < 2) && !abort_i;
      chk("cs", sram_cs_o, exp_iss);
      chk("oe", sram_oe_o, exp_iss);
      chk("addr", sram_addr_o, exp_iss ? exp_addr[iss] : '0);
      chk("wreq", sram_wreq_o, 0);
      chk("valid", wt_valid_o, iss > dlv);
      chk("busy", busy_o, (k >= 1) && (dlv < total));
      chk("done", done_o, (total == 0) ? (k == 1) : (dlv == total && k == last_hs + 1));
      pend      = sram_cs_o;
      pend_addr = sram_addr_o;

      if (prev_hold) begin
        chk("hold_valid", wt_valid_o, 1);
        chk("hold_data", wt_data_o, prev_data);
        chk("hold_last", wt_last_o, prev_last);
      end
      if (wt_valid_o && first_v < 0) first_v = k;
      prev_hold = wt_valid_o && !wt_ready_i;
      prev_data = wt_data_o;
      prev_last = wt_last_o;
      if (wt_valid_o && wt_ready_i) begin
        if (dlv < total) begin
          chk("data", wt_data_o, memf(exp_addr[dlv]));
          chk("last", wt_last_o, (dlv % len) == len - 1);
        end else begin
          chk("word_count", dlv + 1, total);
        end
        dlv++;
        last_hs = k;
      end
      if (exp_iss) iss++;

      if (k == kill_k) begin
        if (kill_rst) begin
          rst = 1'b1;
          #1;
          chk_idle_outputs("rst_async");
          #1 rst = 1'b0;
        end
        break;
      end
      if (dlv >= total && k >= last_hs + 2 && k >= 2) break;
      if (k > 400) begin
        chk("timeout_words", dlv, total);
        break;
      end
      @(posedge clk); #1;
      k++;
    end
    @(posedge clk); #1;

    if (kill_k >= 0) begin
      pend = 0;
      for (int i = 0; i < 4; i++) begin
        start_i = 0; abort_i = 0; sram_gnt_i = 1; wt_ready_i = 1;
        sram_rdata_i = $urandom;
        @(negedge clk);
        chk_idle_outputs(kill_rst ? "after_rst" : "after_abort");
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start_i = 0; abort_i = 0; sram_gnt_i = 1; wt_ready_i = 1;
    base_i = '0; len_i = '0; rep_i = '0; sram_rdata_i = '0;
    pend = 0; pend_addr = '0;
    @(negedge clk);
    chk_idle_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_job(17'h00100, 4, 1, -1, -1, -1, -1, 0, -1, 0, fv);
    chk("t1_first_valid", fv, 2);
    run_job(17'h00100, 3, 2, -1, -1, -1, -1, 0, -1, 0, fv);
    run_job(17'h00100, 4, 1, 3, 7, -1, -1, 0, -1, 0, fv);
    run_job(17'h00100, 4, 1, -1, -1, 3, 6, 0, -1, 0, fv);
    run_job(17'h1FFFE, 4, 1, -1, -1, -1, -1, 0, -1, 0, fv);
    run_job(17'h00040, 0, 3, -1, -1, -1, -1, 0, -1, 0, fv);
    run_job(17'h00040, 5, 0, -1, -1, -1, -1, 0, -1, 0, fv);
    run_job(17'h00200, 8, 2, 4, 5, -1, -1, 0, 5, 0, fv);
    run_job(17'h00300, 8, 2, -1, -1, -1, -1, 0, 4, 1, fv);
    run_job(17'h00000, 1, 1, -1, -1, -1, -1, 0, -1, 0, fv);

    for (int j = 0; j < 16; j++) begin
      run_job(ADDR_W'($urandom), int'($urandom_range(6, 1)), int'($urandom_range(3, 1)),
              -1, -1, -1, -1, 1, -1, 0, fv);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
